// File: rtl/apb_rr_master.sv
// apb_rr_master: round-robin arbitrated APB3 master.
// Shares one APB bus between NREQ local requesters, runs the IDLE/SETUP/ACCESS
// sequence and returns read data / error status to the granted requester.
// All APB outputs and response outputs are registered; req_ready is combinational.
// A watchdog aborts an ACCESS phase after TIMEOUT cycles without pready (0 = off).
//
// Ports:
//   pclk, presetn        clock, asynchronous active-low reset
//   req_valid/write      per-requester request and direction (1 = write)
//   req_addr/req_wdata   flattened per-requester address / write data
//   req_ready            one-hot acceptance pulse (only while idle)
//   rsp_valid            one-hot completion pulse
//   rsp_rdata/rsp_slverr read data (0 for writes and aborts) / error status
//   psel..pslverr        APB3 master-side bus signals
module apb_rr_master #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_slverr,
    output logic               psel,
    output logic               penable,
    output logic               pwrite,
    output logic [AW-1:0]      paddr,
    output logic [DW-1:0]      pwdata,
    input  logic [DW-1:0]      prdata,
    input  logic               pready,
    input  logic               pslverr
);

    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            psel_q, psel_d;
    logic            penable_q, penable_d;
    logic            pwrite_q, pwrite_d;
    logic [AW-1:0]   paddr_q, paddr_d;
    logic [DW-1:0]   pwdata_q, pwdata_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_slverr_q, rsp_slverr_d;

    logic            arb_hit;
    logic [PW-1:0]   arb_idx;
    logic [PW-1:0]   cand;
    logic            wd_expire;

    // First pending requester at or after rr_ptr, wrapping.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((32'(rr_ptr_q) + 32'(k)) % NREQ);
            if (!arb_hit && req_valid[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
    end

    // Gated by presetn so no acceptance is signalled while reset is held.
    always_comb begin
        req_ready = '0;
        if (state_q == ST_IDLE && arb_hit && presetn) begin
            req_ready[arb_idx] = 1'b1;
        end
    end

    // Counter value is the number of completed ACCESS cycles so far.
    assign wd_expire = (TIMEOUT != 0) && ((32'(wait_cnt_q) + 32'd1) == TIMEOUT);

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_d        = gnt_q;
        wait_cnt_d   = wait_cnt_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = '0;
        rsp_slverr_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_hit) begin
                    gnt_d     = arb_idx;
                    pwrite_d  = req_write[arb_idx];
                    paddr_d   = req_addr[arb_idx*AW +: AW];
                    pwdata_d  = req_wdata[arb_idx*DW +: DW];
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    rr_ptr_d  = PW'((32'(arb_idx) + 32'd1) % NREQ);
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d  = 1'b1;
                wait_cnt_d = '0;
                state_d    = ST_ACCESS;
            end
            ST_ACCESS: begin
                // pready takes priority over a simultaneous watchdog expiry.
                if (pready || wd_expire) begin
                    psel_d             = 1'b0;
                    penable_d          = 1'b0;
                    rsp_valid_d[gnt_q] = 1'b1;
                    rsp_rdata_d        = (pready && !pwrite_q) ? prdata : '0;
                    rsp_slverr_d       = pready ? pslverr : 1'b1;
                    wait_cnt_d         = '0;
                    state_d            = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            gnt_q        <= '0;
            wait_cnt_q   <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_q        <= gnt_d;
            wait_cnt_q   <= wait_cnt_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_slverr_q <= rsp_slverr_d;
        end
    end

    assign psel       = psel_q;
    assign penable    = penable_q;
    assign pwrite     = pwrite_q;
    assign paddr      = paddr_q;
    assign pwdata     = pwdata_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_slverr = rsp_slverr_q;

endmodule
